instruction_fetch: RTL and testbench

Front-end stage directly upstream of the control decoder.
- Holds the PC and fetches a 32-bit LEGv8 instruction from instruction memory over a req/ack handshake.
- Presents the instruction and its 11-bit opcode field (instr[31:21]) to decode/control with a valid/ready handshake.
- Computes the next PC from the branch, uncond_branch and zero results returned by the downstream datapath for the instruction currently presented.

---
 rtl/instruction_fetch_pkg.sv | 15 +
 rtl/instruction_fetch_if.sv | 37 +++
 rtl/instruction_fetch_next_pc_logic.sv | 26 ++
 rtl/instruction_fetch.sv | 98 +++++++++
 tb/tb_instruction_fetch.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared state encoding and field constants for instruction fetch
package instruction_fetch_pkg;

  typedef enum logic [0:0] {
    S_REQ   = 1'b0,
    S_VALID = 1'b1
  } fetch_state_e;

  localparam int INSTR_BYTES  = 4;
  localparam int BRANCH_SHIFT = 2;
  localparam int OPCODE_MSB   = 31;
  localparam int OPCODE_LSB   = 21;
  localparam int OPCODE_W     = OPCODE_MSB - OPCODE_LSB + 1;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - memory and decode handshake bundle for instruction fetch
interface instruction_fetch_if
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 32
);

  logic                imem_req;
  logic [ADDR_W-1:0]   imem_addr;
  logic                imem_ack;
  logic [INSTR_W-1:0]  imem_rdata;
  logic [INSTR_W-1:0]  instr;
  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   pc;
  logic                instr_valid;
  logic                instr_ready;
  logic                branch;
  logic                uncond_branch;
  logic                zero;
  logic [ADDR_W-1:0]   signext_imm;
  logic [CNT_W-1:0]    retired_count;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr, opcode, pc, instr_valid, retired_count,
    input  imem_ack, imem_rdata, instr_ready, branch, uncond_branch, zero, signext_imm
  );

  // Memory plus decode/datapath side
  modport slave (
    input  imem_req, imem_addr, instr, opcode, pc, instr_valid, retired_count,
    output imem_ack, imem_rdata, instr_ready, branch, uncond_branch, zero, signext_imm
  );

endinterface

// File: rtl/instruction_fetch_next_pc_logic.sv
// rtl/instruction_fetch_next_pc_logic.sv - combinational next-PC and branch-take selection
module instruction_fetch_next_pc_logic
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] signext_imm,
  input  logic              branch,
  input  logic              uncond_branch,
  input  logic              zero,
  output logic [ADDR_W-1:0] next_pc,
  output logic              take
);

  // uncond_branch is ORed first so an undefined branch line still gives a defined take for B
  always_comb begin
    take = uncond_branch | (branch & zero);
    if (take) begin
      next_pc = pc + (signext_imm << BRANCH_SHIFT);
    end else begin
      next_pc = pc + ADDR_W'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC holder, instruction memory requester and decode presenter
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int              ADDR_W   = 64,
  parameter int              INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
  parameter int              CNT_W    = 32
) (
  input logic CLK,
  input logic Reset,
  instruction_fetch_if.master bus
);

  fetch_state_e       state;
  fetch_state_e       state_next;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  next_pc;
  logic [INSTR_W-1:0] instr_q;
  logic [CNT_W-1:0]   count_q;
  logic               take;
  logic               capture;
  logic               advance;

  instruction_fetch_next_pc_logic #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .pc            (pc_q),
    .signext_imm   (bus.signext_imm),
    .branch        (bus.branch),
    .uncond_branch (bus.uncond_branch),
    .zero          (bus.zero),
    .next_pc       (next_pc),
    .take          (take)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_REQ;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs; both handshakes are forced low while Reset is high
  always_comb begin
    state_next      = state;
    capture         = 1'b0;
    advance         = 1'b0;
    bus.imem_req    = 1'b0;
    bus.instr_valid = 1'b0;
    case (state)
      S_REQ: begin
        bus.imem_req = ~Reset;
        if (bus.imem_ack) begin
          capture    = 1'b1;
          state_next = S_VALID;
        end
      end
      S_VALID: begin
        bus.instr_valid = ~Reset;
        if (bus.instr_ready) begin
          advance    = 1'b1;
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

  // PC, latched instruction and retire counter; a concurrent reset discards ack data
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      if (capture) begin
        instr_q <= bus.imem_rdata;
      end
      if (advance) begin
        pc_q    <= next_pc;
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.pc            = pc_q;
  assign bus.instr         = instr_q;
  assign bus.opcode        = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign bus.retired_count = count_q;

  a_uncond_takes: assert property (@(posedge CLK) disable iff (Reset)
    (advance && bus.uncond_branch) |-> take);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized model-checked bench for instruction_fetch
module tb_instruction_fetch;

  logic CLK;
  logic Reset;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;

  logic        m_known = 1'b0;
  logic        m_valid;
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic cycle(input logic rst, input logic ack, input logic [31:0] rdata,
                       input logic ready, input logic br, input logic ub, input logic z,
                       input logic [63:0] imm);
    logic tk;
    @(negedge CLK);
    Reset             = rst;
    bus.imem_ack      = ack;
    bus.imem_rdata    = rdata;
    bus.instr_ready   = ready;
    bus.branch        = br;
    bus.uncond_branch = ub;
    bus.zero          = z;
    bus.signext_imm   = imm;
    #1;
    if (m_known) begin
      check("imem_req", 64'(bus.imem_req), 64'(!rst && !m_valid));
      check("instr_valid", 64'(bus.instr_valid), 64'(!rst && m_valid));
      if (!rst && !m_valid) check("imem_addr", bus.imem_addr, m_pc);
      if (!rst && m_valid) begin
        check("instr", 64'(bus.instr), 64'(m_instr));
        check("opcode", 64'(bus.opcode), 64'(m_instr >> 21));
        check("pc", bus.pc, m_pc);
      end
      check("retired_count", 64'(bus.retired_count), 64'(m_cnt));
    end
    if (rst) begin
      m_known = 1'b1;
      m_valid = 1'b0;
      m_pc    = 64'h0;
      m_cnt   = 32'h0;
    end else if (m_known) begin
      if (!m_valid && ack) begin
        m_instr = rdata;
        m_valid = 1'b1;
      end else if (m_valid && ready) begin
        tk = ub || (br && z);
        m_pc  = tk ? m_pc + imm * 64'd4 : m_pc + 64'd4;
        m_cnt = m_cnt + 32'd1;
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic ack_with(input logic [31:0] d);
    cycle(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic retire(input logic br, input logic ub, input logic z, input logic [63:0] imm);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, br, ub, z, imm);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    logic [63:0] addrs[$];
    logic [31:0] held_instr;
    logic [10:0] held_op;
    int          s;
    logic [63:0] imm;

    Reset = 1'b1;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
    bus.branch = 1'b0; bus.uncond_branch = 1'b0; bus.zero = 1'b0; bus.signext_imm = '0;

    do_reset();
    do_reset();
    check("req_in_reset", 64'(bus.imem_req), 64'h0);
    check("valid_in_reset", 64'(bus.instr_valid), 64'h0);

    // Straight-line fetch, ack and ready every cycle
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
      if (i == 0) begin
        check("reset_instr", 64'(bus.instr), 64'h0);
        check("reset_count", 64'(bus.retired_count), 64'h0);
      end
      if (bus.imem_req) addrs.push_back(bus.imem_addr);
    end
    check("n_requests", 64'(addrs.size()), 64'd4);
    for (int i = 0; i < addrs.size() && i < 4; i++) check("seq_addr", addrs[i], 64'(4 * i));
    idle();
    check("count_after_4", 64'(bus.retired_count), 64'd4);

    // Delayed ack
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      check("wait_req", 64'(bus.imem_req), 64'h1);
      check("wait_addr", bus.imem_addr, 64'h0);
      check("wait_valid", 64'(bus.instr_valid), 64'h0);
    end
    ack_with(32'h8B02_0020);
    idle();
    check("late_valid", 64'(bus.instr_valid), 64'h1);
    check("late_instr", 64'(bus.instr), 64'h8B02_0020);
    check("late_opcode", 64'(bus.opcode), 64'h458);

    // Stall at 0x100 then taken conditional branch backwards
    retire(1'b0, 1'b1, 1'b0, 64'h40);
    ack_with(32'hB400_0123);
    held_instr = bus.instr;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, $urandom, 1'b0, $urandom, $urandom, $urandom, {$urandom, $urandom});
      if (i == 0) begin
        held_instr = bus.instr;
        held_op    = bus.opcode;
      end
      check("stall_pc", bus.pc, 64'h100);
      check("stall_instr", 64'(bus.instr), 64'(held_instr));
      check("stall_opcode", 64'(bus.opcode), 64'(held_op));
    end
    check("stall_instr_lit", 64'(bus.instr), 64'hB400_0123);
    retire(1'b1, 1'b0, 1'b1, -64'sd4);
    idle();
    check("branch_back_addr", bus.imem_addr, 64'hF0);

    // Not-taken conditional, then unconditional with undefined branch
    ack_with($urandom);
    retire(1'b0, 1'b1, 1'b0, 64'd4);
    ack_with($urandom);
    retire(1'b1, 1'b0, 1'b0, 64'd8);
    idle();
    check("not_taken_addr", bus.imem_addr, 64'h104);
    ack_with($urandom);
    retire(1'b0, 1'b1, 1'b0, -64'sd1);
    ack_with($urandom);
    retire(1'bx, 1'b1, 1'b0, 64'd8);
    idle();
    check("uncond_addr", bus.imem_addr, 64'h120);

    // PC wrap
    do_reset();
    ack_with($urandom);
    retire(1'b0, 1'b1, 1'b0, -64'sd1);
    idle();
    check("top_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    ack_with($urandom);
    retire(1'b0, 1'b0, 1'b0, 64'h0);
    idle();
    check("wrap_addr", bus.imem_addr, 64'h0);

    // Reset in S_VALID with ack, then in S_REQ with ack
    ack_with($urandom);
    retire(1'b0, 1'b0, 1'b0, 64'h0);
    ack_with(32'hDEAD_BEEF);
    cycle(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    idle();
    check("rstv_valid", 64'(bus.instr_valid), 64'h0);
    check("rstv_req", 64'(bus.imem_req), 64'h1);
    check("rstv_addr", bus.imem_addr, 64'h0);
    check("rstv_count", 64'(bus.retired_count), 64'h0);
    ack_with($urandom);
    retire(1'b0, 1'b0, 1'b0, 64'h0);
    cycle(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    idle();
    check("rstr_valid", 64'(bus.instr_valid), 64'h0);
    check("rstr_req", 64'(bus.imem_req), 64'h1);
    check("rstr_addr", bus.imem_addr, 64'h0);
    check("rstr_count", 64'(bus.retired_count), 64'h0);
    check("rstr_instr", 64'(bus.instr), 64'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      s = int'($urandom_range(0, 64)) - 32;
      imm = {{32{s[31]}}, s};
      if ($urandom_range(0, 15) == 0) imm = {$urandom, $urandom};
      cycle(($urandom_range(0, 99) == 0), $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, imm);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
